// File: rtl/uart_pkt_parser_pkg.sv
// Shared types and default constants for the UART packet framer.
package uart_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR1,
        ST_PAYLOAD,
        ST_CSUM
    } pkt_state_t;

    localparam logic [7:0]  PKT_HDR0        = 8'h55;
    localparam logic [7:0]  PKT_HDR1        = 8'hAA;
    localparam int unsigned PKT_NUM_BYTES   = 12;
    localparam int unsigned PKT_TIMEOUT_CYC = 50000;
    localparam int unsigned PKT_IDX_W       = $clog2(PKT_NUM_BYTES);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_pkt_parser_if.sv
// Byte-stream input and verified-frame output bundle of the packet framer.
interface uart_pkt_parser_if #(
    parameter int unsigned _NUM_BYTES = uart_pkt_pkg::PKT_NUM_BYTES
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [_NUM_BYTES*8-1:0] frame_data;
    logic                    frame_valid;
    logic                    csum_err;
    logic                    timeout_err;
    logic                    busy;
    logic [7:0]              frame_cnt;
    logic [7:0]              err_cnt;

    modport master (
        output rx_data, rx_valid,
        input  frame_data, frame_valid, csum_err, timeout_err, busy, frame_cnt, err_cnt
    );

    modport slave (
        input  rx_data, rx_valid,
        output frame_data, frame_valid, csum_err, timeout_err, busy, frame_cnt, err_cnt
    );
endinterface

// File: rtl/uart_pkt_parser_gap_timer.sv
// Inter-byte gap timer; expired fires so the registered error lands exactly
// _TIMEOUT_CYC cycles after the last strobe, and a coinciding byte suppresses it.
module pkt_gap_timer #(
    parameter int unsigned _TIMEOUT_CYC = uart_pkt_pkg::PKT_TIMEOUT_CYC
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int unsigned CW = $clog2(_TIMEOUT_CYC);

    logic [CW-1:0] r_cnt;

    assign expired = run && !clear && (r_cnt == CW'(_TIMEOUT_CYC - 2));

    always_ff @(posedge clk_50M) begin
        if (rst || clear || !run || expired) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_pkt_parser.sv
// Header hunt, fixed-length payload capture and additive checksum check;
// only verified frames reach frame_data.
module uart_pkt_parser
    import uart_pkt_pkg::*;
#(
    parameter int unsigned _NUM_BYTES   = PKT_NUM_BYTES,
    parameter logic [7:0]  _HDR0        = PKT_HDR0,
    parameter logic [7:0]  _HDR1        = PKT_HDR1,
    parameter int unsigned _TIMEOUT_CYC = PKT_TIMEOUT_CYC
) (
    input  logic             clk_50M,
    input  logic             rst,
    uart_pkt_parser_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(_NUM_BYTES);

    pkt_state_t              r_state;
    pkt_state_t              w_next;
    logic [IDX_W-1:0]        r_idx;
    logic [7:0]              r_acc;
    logic [_NUM_BYTES*8-1:0] r_shadow;
    logic [_NUM_BYTES*8-1:0] r_frame_data;
    logic                    r_frame_valid;
    logic                    r_csum_err;
    logic                    r_timeout_err;
    logic [7:0]              r_frame_cnt;
    logic [7:0]              r_err_cnt;
    logic                    w_start;
    logic                    w_wr;
    logic                    w_good;
    logic                    w_bad;
    logic                    w_expired;

    pkt_gap_timer #(._TIMEOUT_CYC(_TIMEOUT_CYC)) u_gap_timer (
        .clk_50M (clk_50M),
        .rst     (rst),
        .clear   (bus.rx_valid),
        .run     (r_state != ST_IDLE),
        .expired (w_expired)
    );

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_wr    = 1'b0;
        w_good  = 1'b0;
        w_bad   = 1'b0;
        if (w_expired) begin
            w_next = ST_IDLE;
        end else if (bus.rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_data == _HDR0) w_next = ST_HDR1;
                end
                ST_HDR1: begin
                    if (bus.rx_data == _HDR1) begin
                        w_next  = ST_PAYLOAD;
                        w_start = 1'b1;
                    end else if (bus.rx_data != _HDR0) begin
                        w_next = ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    w_wr = 1'b1;
                    if (r_idx == IDX_W'(_NUM_BYTES - 1)) w_next = ST_CSUM;
                end
                ST_CSUM: begin
                    w_next = ST_IDLE;
                    if (bus.rx_data == r_acc) w_good = 1'b1;
                    else                      w_bad  = 1'b1;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_acc         <= '0;
            r_shadow      <= '0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_csum_err    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_frame_cnt   <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_state       <= w_next;
            r_frame_valid <= w_good;
            r_csum_err    <= w_bad;
            r_timeout_err <= w_expired;
            if (w_start) begin
                r_idx <= '0;
                r_acc <= '0;
            end
            if (w_wr) begin
                r_shadow[8*int'(r_idx) +: 8] <= bus.rx_data;
                r_acc                        <= r_acc + bus.rx_data;
                r_idx                        <= r_idx + 1'b1;
            end
            if (w_expired) r_shadow <= '0;
            if (w_good) begin
                r_frame_data <= r_shadow;
                r_frame_cnt  <= sat_inc(r_frame_cnt);
            end
            if (w_bad || w_expired) r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign bus.frame_data  = r_frame_data;
    assign bus.frame_valid = r_frame_valid;
    assign bus.csum_err    = r_csum_err;
    assign bus.timeout_err = r_timeout_err;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: good/bad frames, resync, gap timeout,
// timeout/byte coincidence, mid-frame reset, back-to-back frames, saturation.
module tb_uart_pkt_parser;
    localparam int unsigned NB = 12;
    localparam int unsigned TO = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_pkt_parser_if #(._NUM_BYTES(NB)) bus ();

    uart_pkt_parser #(._NUM_BYTES(NB), ._TIMEOUT_CYC(TO)) dut (
        .clk_50M (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned fv_seen = 0;
    int unsigned ce_seen = 0;
    int unsigned to_seen = 0;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_seen++;
        if (bus.csum_err === 1'b1)    ce_seen++;
        if (bus.timeout_err === 1'b1) to_seen++;
    end

    function automatic logic [NB*8-1:0] ramp();
        logic [NB*8-1:0] p;
        for (int k = 0; k < NB; k++) p[8*k +: 8] = 8'(k + 1);
        return p;
    endfunction

    task automatic strobe(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [NB*8-1:0] pl, input logic [7:0] cs);
        strobe(8'h55);
        strobe(8'hAA);
        for (int k = 0; k < NB; k++) strobe(pl[8*k +: 8]);
        strobe(cs);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(3);
        vectors++; if (bus.frame_data !== '0) begin miscompares++; $display("FAIL rst_data: got %0h expected 0", bus.frame_data); end
        vectors++; if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL rst_fv: got %0b expected 0", bus.frame_valid); end
        vectors++; if (bus.csum_err !== 1'b0) begin miscompares++; $display("FAIL rst_ce: got %0b expected 0", bus.csum_err); end
        vectors++; if (bus.timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_to: got %0b expected 0", bus.timeout_err); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b expected 0", bus.busy); end
        vectors++; if (bus.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_fcnt: got %0d expected 0", bus.frame_cnt); end
        vectors++; if (bus.err_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_ecnt: got %0d expected 0", bus.err_cnt); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_good_frame();
        int unsigned fv0;
        fv0 = fv_seen;
        send_frame(ramp(), 8'h4E);
        vectors++; if (bus.frame_valid !== 1'b1) begin miscompares++; $display("FAIL good_fv: got %0b expected 1", bus.frame_valid); end
        vectors++; if (bus.frame_data !== ramp()) begin miscompares++; $display("FAIL good_data: got %0h expected %0h", bus.frame_data, ramp()); end
        vectors++; if (bus.frame_cnt !== 8'd1) begin miscompares++; $display("FAIL good_fcnt: got %0d expected 1", bus.frame_cnt); end
        vectors++; if (bus.csum_err !== 1'b0) begin miscompares++; $display("FAIL good_ce: got %0b expected 0", bus.csum_err); end
        idle(1);
        vectors++; if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL good_fv_end: got %0b expected 0", bus.frame_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL good_busy: got %0b expected 0", bus.busy); end
        vectors++; if (fv_seen - fv0 !== 1) begin miscompares++; $display("FAIL good_pulses: got %0d expected 1", fv_seen - fv0); end
    endtask

    task automatic test_bad_csum();
        send_frame(ramp(), 8'h4F);
        vectors++; if (bus.csum_err !== 1'b1) begin miscompares++; $display("FAIL bad_ce: got %0b expected 1", bus.csum_err); end
        vectors++; if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL bad_fv: got %0b expected 0", bus.frame_valid); end
        vectors++; if (bus.err_cnt !== 8'd1) begin miscompares++; $display("FAIL bad_ecnt: got %0d expected 1", bus.err_cnt); end
        vectors++; if (bus.frame_cnt !== 8'd1) begin miscompares++; $display("FAIL bad_fcnt: got %0d expected 1", bus.frame_cnt); end
        vectors++; if (bus.frame_data !== ramp()) begin miscompares++; $display("FAIL bad_data: got %0h expected %0h", bus.frame_data, ramp()); end
        idle(1);
        vectors++; if (bus.csum_err !== 1'b0) begin miscompares++; $display("FAIL bad_ce_end: got %0b expected 0", bus.csum_err); end
    endtask

    task automatic test_resync();
        int unsigned fv0, ce0, to0;
        strobe(8'h55);
        send_frame('0, 8'h00);
        vectors++; if (bus.frame_valid !== 1'b1) begin miscompares++; $display("FAIL resync_fv: got %0b expected 1", bus.frame_valid); end
        vectors++; if (bus.frame_data !== '0) begin miscompares++; $display("FAIL resync_data: got %0h expected 0", bus.frame_data); end
        vectors++; if (bus.frame_cnt !== 8'd2) begin miscompares++; $display("FAIL resync_fcnt: got %0d expected 2", bus.frame_cnt); end
        idle(1);
        fv0 = fv_seen; ce0 = ce_seen; to0 = to_seen;
        strobe(8'h55);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_hi: got %0b expected 1", bus.busy); end
        strobe(8'h12);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy_lo: got %0b expected 0", bus.busy); end
        idle(2);
        vectors++; if (bus.err_cnt !== 8'd1) begin miscompares++; $display("FAIL abort_ecnt: got %0d expected 1", bus.err_cnt); end
        vectors++; if ((fv_seen - fv0) + (ce_seen - ce0) + (to_seen - to0) !== 0) begin
            miscompares++; $display("FAIL abort_pulses: got %0d expected 0", (fv_seen - fv0) + (ce_seen - ce0) + (to_seen - to0));
        end
    endtask

    task automatic test_timeout();
        int unsigned to0;
        to0 = to_seen;
        strobe(8'h55); strobe(8'hAA); strobe(8'h01); strobe(8'h02);
        idle(TO - 2);
        vectors++; if (bus.timeout_err !== 1'b0 || to_seen != to0) begin miscompares++; $display("FAIL to_early: got %0d pulses expected 0", to_seen - to0); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL to_busy_wait: got %0b expected 1", bus.busy); end
        idle(1);
        vectors++; if (bus.timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_pulse: got %0b expected 1", bus.timeout_err); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL to_busy: got %0b expected 0", bus.busy); end
        vectors++; if (bus.err_cnt !== 8'd2) begin miscompares++; $display("FAIL to_ecnt: got %0d expected 2", bus.err_cnt); end
        vectors++; if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL to_fv: got %0b expected 0", bus.frame_valid); end
        idle(1);
        vectors++; if (bus.timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_pulse_end: got %0b expected 0", bus.timeout_err); end
        send_frame(ramp(), 8'h4E);
        vectors++; if (bus.frame_valid !== 1'b1) begin miscompares++; $display("FAIL to_next_fv: got %0b expected 1", bus.frame_valid); end
        vectors++; if (bus.frame_cnt !== 8'd3) begin miscompares++; $display("FAIL to_next_fcnt: got %0d expected 3", bus.frame_cnt); end
        idle(1);
    endtask

    task automatic test_gap_boundary();
        int unsigned to0;
        to0 = to_seen;
        strobe(8'h55); strobe(8'hAA); strobe(8'h01);
        idle(TO - 2);
        strobe(8'h02);
        vectors++; if (bus.timeout_err !== 1'b0) begin miscompares++; $display("FAIL edge_to: got %0b expected 0", bus.timeout_err); end
        for (int k = 3; k <= NB; k++) strobe(8'(k));
        strobe(8'h4E);
        vectors++; if (bus.frame_valid !== 1'b1) begin miscompares++; $display("FAIL edge_fv: got %0b expected 1", bus.frame_valid); end
        vectors++; if (bus.frame_data !== ramp()) begin miscompares++; $display("FAIL edge_data: got %0h expected %0h", bus.frame_data, ramp()); end
        vectors++; if (bus.frame_cnt !== 8'd4) begin miscompares++; $display("FAIL edge_fcnt: got %0d expected 4", bus.frame_cnt); end
        vectors++; if (bus.err_cnt !== 8'd2) begin miscompares++; $display("FAIL edge_ecnt: got %0d expected 2", bus.err_cnt); end
        vectors++; if (to_seen != to0) begin miscompares++; $display("FAIL edge_pulses: got %0d expected 0", to_seen - to0); end
        idle(1);
    endtask

    task automatic test_rst_mid();
        int unsigned to0;
        strobe(8'h55); strobe(8'hAA); strobe(8'h01); strobe(8'h02); strobe(8'h03);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mrst_busy_pre: got %0b expected 1", bus.busy); end
        rst = 1'b1;
        idle(1);
        vectors++; if (bus.frame_data !== '0) begin miscompares++; $display("FAIL mrst_data: got %0h expected 0", bus.frame_data); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mrst_busy: got %0b expected 0", bus.busy); end
        vectors++; if (bus.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL mrst_fcnt: got %0d expected 0", bus.frame_cnt); end
        vectors++; if (bus.err_cnt !== 8'd0) begin miscompares++; $display("FAIL mrst_ecnt: got %0d expected 0", bus.err_cnt); end
        vectors++; if (bus.frame_valid !== 1'b0 || bus.csum_err !== 1'b0 || bus.timeout_err !== 1'b0) begin
            miscompares++; $display("FAIL mrst_pulses: got fv=%0b ce=%0b to=%0b expected 0", bus.frame_valid, bus.csum_err, bus.timeout_err);
        end
        rst = 1'b0;
        to0 = to_seen;
        idle(TO + 5);
        vectors++; if (to_seen != to0 || bus.err_cnt !== 8'd0) begin
            miscompares++; $display("FAIL mrst_after: got to=%0d ecnt=%0d expected 0 0", to_seen - to0, bus.err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [NB*8-1:0] pl2;
        int unsigned fv0;
        pl2 = '0;
        pl2[7:0]   = 8'h55;
        pl2[15:8]  = 8'hAA;
        pl2[23:16] = 8'h55;
        pl2[31:24] = 8'hAA;
        pl2[95:88] = 8'hFF;
        fv0 = fv_seen;
        send_frame(ramp(), 8'h4E);
        vectors++; if (bus.frame_valid !== 1'b1 || bus.frame_data !== ramp()) begin
            miscompares++; $display("FAIL b2b_first: got fv=%0b data=%0h expected 1 %0h", bus.frame_valid, bus.frame_data, ramp());
        end
        send_frame(pl2, 8'hFD);
        vectors++; if (bus.frame_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_fv: got %0b expected 1", bus.frame_valid); end
        vectors++; if (bus.frame_data !== pl2) begin miscompares++; $display("FAIL b2b_data: got %0h expected %0h", bus.frame_data, pl2); end
        vectors++; if (bus.frame_cnt !== 8'd2) begin miscompares++; $display("FAIL b2b_fcnt: got %0d expected 2", bus.frame_cnt); end
        idle(1);
        vectors++; if (fv_seen - fv0 !== 2) begin miscompares++; $display("FAIL b2b_pulses: got %0d expected 2", fv_seen - fv0); end
    endtask

    task automatic test_saturation();
        int unsigned ce0;
        logic [7:0]  exp_cnt;
        ce0 = ce_seen;
        for (int i = 0; i < 300; i++) begin
            send_frame('0, 8'h01);
            exp_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            vectors++; if (bus.csum_err !== 1'b1) begin miscompares++; $display("FAIL sat_ce[%0d]: got %0b expected 1", i, bus.csum_err); end
            vectors++; if (bus.err_cnt !== exp_cnt) begin miscompares++; $display("FAIL sat_ecnt[%0d]: got %0d expected %0d", i, bus.err_cnt, exp_cnt); end
        end
        idle(1);
        vectors++; if (ce_seen - ce0 !== 300) begin miscompares++; $display("FAIL sat_pulses: got %0d expected 300", ce_seen - ce0); end
        vectors++; if (bus.err_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_final: got %0d expected 255", bus.err_cnt); end
        vectors++; if (bus.frame_cnt !== 8'd2) begin miscompares++; $display("FAIL sat_fcnt: got %0d expected 2", bus.frame_cnt); end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #1;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_resync();
        test_timeout();
        test_gap_boundary();
        test_rst_mid();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_pkt_parser.md
# uart_pkt_parser

Byte-stream framer between the UART receiver and `uart_reg_mapper`. It consumes the receiver's one-cycle byte strobes and hunts for the header `0x55 0xAA`. It then collects a fixed-length payload and checks an 8-bit additive checksum. Only verified frames are published to the mapper, as a parallel payload bus with a one-cycle `frame_valid` pulse. Malformed, truncated or stalled frames are dropped and counted.

## Interface
- `_NUM_BYTES`, 12: payload bytes per frame (byte 0 is the function register).
- `_HDR0`, 8'h55: first header byte.
- `_HDR1`, 8'hAA: second header byte.
- `_TIMEOUT_CYC`, 50000: maximum idle cycles between bytes inside a frame (1 ms at 50 MHz).

Ports:
- `clk_50M` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `rx_data` in 8: received byte, valid when `rx_valid`=1.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `frame_data` out `_NUM_BYTES*8`: last verified payload; byte k sits in [8k+7:8k].
- `frame_valid` out 1: one-cycle pulse when `frame_data` is updated.
- `csum_err` out 1: one-cycle pulse when a frame is dropped for a checksum mismatch.
- `timeout_err` out 1: one-cycle pulse when a frame is dropped for an inter-byte gap.
- `busy` out 1: high in any state other than IDLE.
- `frame_cnt` out 8: count of good frames, saturating at 255.
- `err_cnt` out 8: count of checksum errors plus timeouts, saturating at 255.

## Operation
Frame format on the wire: `_HDR0`, `_HDR1`, payload[0..`_NUM_BYTES`-1], csum.
- csum = (sum of the payload bytes) mod 256.
- The header bytes are not included in the sum.

State machine (the state advances only on `rx_valid` unless noted):
- **IDLE**
  - byte == `_HDR0` → HDR1.
  - any other byte is ignored.
- **HDR1**
  - byte == `_HDR1` → PAYLOAD; clear the byte index and the accumulator.
  - byte == `_HDR0` → stay in HDR1 (resync on a repeated 0x55).
  - any other byte → IDLE.
- **PAYLOAD**
  - Write the byte into the shadow buffer at the current index.
  - Add the byte to the 8-bit accumulator (wraps mod 256).
  - Increment the index.
  - When the index reaches `_NUM_BYTES`-1 on a write → CSUM.
- **CSUM**
  - byte == accumulator: copy the shadow buffer to `frame_data`, pulse `frame_valid`, increment `frame_cnt`.
  - otherwise: pulse `csum_err`, increment `err_cnt`; `frame_data` is unchanged.
  - Either way → IDLE.
- **Gap timer**
  - Clears on every `rx_valid` and counts while the state is not IDLE.
  - On reaching `_TIMEOUT_CYC`-1: pulse `timeout_err`, increment `err_cnt`, go to IDLE, discard the shadow buffer.
- Header bytes are never treated as data once the state is PAYLOAD; 0x55 and 0xAA are valid payload values.
- `frame_data` only ever holds a fully verified frame. It never shows a partial frame.

## Timing
- Reset values: `frame_data`=0, `frame_valid`=0, `csum_err`=0, `timeout_err`=0, `busy`=0, `frame_cnt`=0, `err_cnt`=0, state=IDLE, timer=0.
- Latency: checksum byte strobe at cycle N → `frame_valid` and new `frame_data` at N+1.
  - `frame_data` then holds until the next good frame.
  - The same N+1 rule applies to `csum_err`.
- `rx_valid` may assert on consecutive cycles; no byte may be lost at full rate.
- Timeout: if the last byte strobe is at cycle N and no further strobe arrives, `timeout_err` pulses at cycle N+`_TIMEOUT_CYC`.
- If `rx_valid` and timer expiry coincide, the byte wins: the timer clears and no timeout is raised.
- `rst` asserted mid-frame: the partial frame is discarded, all outputs return to their reset values on the next edge, and no error is counted.
- Counter saturation: at 255 the counter holds. A simultaneous pulse on a saturated counter is still emitted.
- `frame_valid` and `csum_err` are mutually exclusive in any cycle. A timeout cannot coincide with either.

## Structure
- Package `uart_pkt_pkg` holds:
  - the state enum (IDLE, HDR1, PAYLOAD, CSUM);
  - default header constants;
  - the frame-length constant;
  - the index width, `$clog2(_NUM_BYTES)`.
- One sub-module, `pkt_gap_timer`:
  - inputs: `clk_50M`, `rst`, `clear`, `run`;
  - output: a one-cycle `expired` pulse;
  - parameter: `_TIMEOUT_CYC`.
- Everything else stays in `uart_pkt_parser`.

## Test plan
- Good frame: send 55 AA 01..0C 4E back-to-back → `frame_valid` one cycle after 4E, `frame_data` bytes 0..11 = 01..0C, `frame_cnt`=1.
- Bad checksum: send the same frame with csum 4F → `csum_err` pulse, `err_cnt`=1, `frame_data` still 0 (or the previous good frame).
- Resync: send 55 55 AA + 12×00 + 00 → one `frame_valid`, payload all zero. Also send 55 12 → returns to IDLE with no error.
- Timeout: send 55 AA 01 02, then idle 50000 cycles → `timeout_err` exactly 50000 cycles after 02, `busy`=0. A following good frame is accepted.
- Boundary: deliver a byte on the same cycle as timer expiry → no `timeout_err`, and the frame completes normally. Assert `rst` mid-payload → outputs go to their reset values and `err_cnt` is unchanged.
- Saturation: 300 bad-checksum frames → `err_cnt` holds at 255, and every `csum_err` pulse is still emitted.
